// File: rtl/date_pair_collector_if.sv
// Date-pair stream bundle: input date stream, held output pair, error and count status.
// Latency: none, wires only.
// Backpressure: in_ready stalls the date producer; out_ready lets the consumer stall the pair.
interface date_pair_collector_if;
    logic       clear;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_day;
    logic [3:0] in_mon;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] day1;
    logic [3:0] mon1;
    logic [4:0] day2;
    logic [3:0] mon2;
    logic       err;
    logic [1:0] err_code;
    logic [7:0] pair_cnt;

    // Producer/consumer side (drives dates, takes pairs).
    modport master (
        output clear, in_valid, in_day, in_mon, out_ready,
        input  in_ready, out_valid, day1, mon1, day2, mon2, err, err_code, pair_cnt
    );

    // Collector side.
    modport slave (
        input  clear, in_valid, in_day, in_mon, out_ready,
        output in_ready, out_valid, day1, mon1, day2, mon2, err, err_code, pair_cnt
    );
endinterface

// File: rtl/date_pair_collector.sv
// Collects two range-checked calendar dates into a held pair for the date-difference datapath.
// Latency: out_valid rises the cycle after the second good date is accepted; one pair per 3 cycles best case.
// Backpressure: in_ready drops while a pair is held; the pair stays stable until out_ready.
module date_pair_collector #(
    // Days in February used for validation; only 28 or 29 are meaningful.
    parameter int FEB_DAYS = 28
) (
    input  logic                  clk,
    input  logic                  rst_n,
    date_pair_collector_if.slave  bus
);

    typedef enum logic [1:0] {
        S_FIRST  = 2'd0,
        S_SECOND = 2'd1,
        S_OUT    = 2'd2
    } state_t;

    localparam logic [4:0] W_FEB_DAYS = 5'(FEB_DAYS);

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_out_valid;
    logic [4:0] r_day1;
    logic [3:0] r_mon1;
    logic [4:0] r_day2;
    logic [3:0] r_mon2;
    logic       r_err;
    logic [1:0] r_err_code;
    logic [7:0] r_pair_cnt;

    logic       w_in_ready;
    logic       w_accept;
    logic [4:0] w_dim;
    logic       w_mon_bad;
    logic       w_day_bad;
    logic       w_good;
    logic       w_reject;
    logic       w_handoff;

    // in_ready depends only on the state so it can never loop back through in_valid.
    assign w_in_ready = (r_state != S_OUT);

    // A date presented during clear is dropped even though in_ready is high.
    assign w_accept   = bus.in_valid & w_in_ready & ~bus.clear;

    // Days in the presented month; out-of-range months are caught by the month check first.
    always_comb begin
        w_dim = 5'd31;
        case (bus.in_mon)
            4'd2:                     w_dim = W_FEB_DAYS;
            4'd4, 4'd6, 4'd9, 4'd11:  w_dim = 5'd30;
            default:                  w_dim = 5'd31;
        endcase
    end

    assign w_mon_bad = (bus.in_mon == 4'd0) || (bus.in_mon > 4'd12);
    assign w_day_bad = (bus.in_day == 5'd0) || (bus.in_day > w_dim);
    assign w_good    = w_accept & ~w_mon_bad & ~w_day_bad;
    assign w_reject  = w_accept & (w_mon_bad | w_day_bad);

    // Output handshake; clear outranks it so a cleared pair is never counted.
    assign w_handoff = (r_state == S_OUT) & bus.out_ready & ~bus.clear;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FIRST;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: advance on good dates, return to S_FIRST on handoff or clear.
    always_comb begin
        w_state_nxt = r_state;
        if (bus.clear) begin
            w_state_nxt = S_FIRST;
        end else begin
            case (r_state)
                S_FIRST:  if (w_good)    w_state_nxt = S_SECOND;
                S_SECOND: if (w_good)    w_state_nxt = S_OUT;
                S_OUT:    if (w_handoff) w_state_nxt = S_FIRST;
                default:                 w_state_nxt = S_FIRST;
            endcase
        end
    end

    // out_valid is its own flop so the consumer sees a clean registered qualifier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= (w_state_nxt == S_OUT);
        end
    end

    // Pair registers: first good date lands in slot 1, second in slot 2; rejects leave them alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_day1 <= 5'd0;
            r_mon1 <= 4'd0;
            r_day2 <= 5'd0;
            r_mon2 <= 4'd0;
        end else if (bus.clear) begin
            r_day1 <= 5'd0;
            r_mon1 <= 4'd0;
            r_day2 <= 5'd0;
            r_mon2 <= 4'd0;
        end else if (w_good && (r_state == S_FIRST)) begin
            r_day1 <= bus.in_day;
            r_mon1 <= bus.in_mon;
        end else if (w_good && (r_state == S_SECOND)) begin
            r_day2 <= bus.in_day;
            r_mon2 <= bus.in_mon;
        end
    end

    // Reject reporting: one-cycle err pulse, sticky code with the month check taking priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
        end else if (bus.clear) begin
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
        end else begin
            r_err <= w_reject;
            if (w_reject) begin
                r_err_code <= w_mon_bad ? 2'b01 : 2'b10;
            end
        end
    end

    // Completed-handshake counter; wraps naturally and survives clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pair_cnt <= 8'd0;
        end else if (w_handoff) begin
            r_pair_cnt <= r_pair_cnt + 8'd1;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.day1      = r_day1;
    assign bus.mon1      = r_mon1;
    assign bus.day2      = r_day2;
    assign bus.mon2      = r_mon2;
    assign bus.err       = r_err;
    assign bus.err_code  = r_err_code;
    assign bus.pair_cnt  = r_pair_cnt;

endmodule

// File: tb/tb_date_pair_collector.sv
// Self-checking bench for date_pair_collector (February=28 and February=29 instances).
// Latency: inputs driven 1ns after a rising edge, outputs sampled 1ns after the next one.
// Backpressure: out_ready driven directly and randomly throttled in the reference-model run.
module tb_date_pair_collector;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_cnt  = 0;

    date_pair_collector_if bus28();
    date_pair_collector_if bus29();

    date_pair_collector #(.FEB_DAYS(28)) dut28 (.clk(clk), .rst_n(rst_n), .bus(bus28.slave));
    date_pair_collector #(.FEB_DAYS(29)) dut29 (.clk(clk), .rst_n(rst_n), .bus(bus29.slave));

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_date(input logic [4:0] d, input logic [3:0] m);
        bus28.in_valid = 1'b1;
        bus28.in_day   = d;
        bus28.in_mon   = m;
        tick();
        bus28.in_valid = 1'b0;
    endtask

    task automatic send29(input logic [4:0] d, input logic [3:0] m);
        bus29.in_valid = 1'b1;
        bus29.in_day   = d;
        bus29.in_mon   = m;
        tick();
        bus29.in_valid = 1'b0;
    endtask

    // Calendar rule: thirty days hath September, April, June and November.
    function automatic int month_len(input int m, input int feb);
        if (m == 2) return feb;
        if (m inside {4, 6, 9, 11}) return 30;
        return 31;
    endfunction

    task automatic test_reset;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (bus28.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 1", bus28.in_ready); end
        n_checks++; if (bus28.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", bus28.out_valid); end
        n_checks++; if (bus28.pair_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_pair_cnt: got %0d want 0", bus28.pair_cnt); end
        n_checks++; if (bus28.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b want 0", bus28.err); end
        n_checks++; if (bus28.err_code !== 2'b00) begin n_fail++; $display("FAIL reset_err_code: got %b want 00", bus28.err_code); end
        n_checks++; if ({bus28.day1, bus28.mon1, bus28.day2, bus28.mon2} !== 18'd0) begin n_fail++; $display("FAIL reset_pair_regs: got %h want 0", {bus28.day1, bus28.mon1, bus28.day2, bus28.mon2}); end
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        exp_cnt = 0;
    endtask

    task automatic test_basic;
        bus28.out_ready = 1'b1;
        send_date(5'd15, 4'd3);
        n_checks++; if (bus28.in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_after_first: got %0b want 1", bus28.in_ready); end
        send_date(5'd20, 4'd7);
        n_checks++; if (bus28.out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_out_valid: got %0b want 1", bus28.out_valid); end
        n_checks++; if ({bus28.day1, bus28.mon1, bus28.day2, bus28.mon2} !== {5'd15, 4'd3, 5'd20, 4'd7}) begin n_fail++; $display("FAIL basic_pair: got %0d/%0d %0d/%0d want 15/3 20/7", bus28.day1, bus28.mon1, bus28.day2, bus28.mon2); end
        n_checks++; if (bus28.in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_in_out: got %0b want 0", bus28.in_ready); end
        tick();
        n_checks++; if (bus28.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_one_cycle: got %0b want 0", bus28.out_valid); end
        n_checks++; if (bus28.pair_cnt !== 8'(exp_cnt + 1)) begin n_fail++; $display("FAIL basic_pair_cnt: got %0d want %0d", bus28.pair_cnt, exp_cnt + 1); end
        n_checks++; if (bus28.in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_again: got %0b want 1", bus28.in_ready); end
        exp_cnt++;
        bus28.out_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        bus28.out_ready = 1'b0;
        send_date(5'd15, 4'd3);
        send_date(5'd20, 4'd7);
        for (int i = 0; i < 5; i++) begin
            bus28.in_valid = 1'b1;
            bus28.in_day   = 5'(i + 1);
            bus28.in_mon   = 4'd1;
            tick();
            n_checks++; if (bus28.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid[%0d]: got %0b want 1", i, bus28.out_valid); end
            n_checks++; if (bus28.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %0b want 0", i, bus28.in_ready); end
            n_checks++; if ({bus28.day1, bus28.mon1, bus28.day2, bus28.mon2} !== {5'd15, 4'd3, 5'd20, 4'd7}) begin n_fail++; $display("FAIL bp_pair_stable[%0d]: got %0d/%0d %0d/%0d want 15/3 20/7", i, bus28.day1, bus28.mon1, bus28.day2, bus28.mon2); end
            n_checks++; if (bus28.pair_cnt !== 8'(exp_cnt)) begin n_fail++; $display("FAIL bp_cnt_held[%0d]: got %0d want %0d", i, bus28.pair_cnt, exp_cnt); end
        end
        bus28.in_valid  = 1'b0;
        bus28.out_ready = 1'b1;
        tick();
        n_checks++; if (bus28.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %0b want 0", bus28.out_valid); end
        n_checks++; if (bus28.pair_cnt !== 8'(exp_cnt + 1)) begin n_fail++; $display("FAIL bp_release_cnt: got %0d want %0d", bus28.pair_cnt, exp_cnt + 1); end
        exp_cnt++;
        bus28.out_ready = 1'b0;
    endtask

    task automatic test_reject_in_second;
        bus28.out_ready = 1'b0;
        send_date(5'd10, 4'd6);
        send_date(5'd31, 4'd4);
        n_checks++; if (bus28.err !== 1'b1) begin n_fail++; $display("FAIL rs_err: got %0b want 1", bus28.err); end
        n_checks++; if (bus28.err_code !== 2'b10) begin n_fail++; $display("FAIL rs_code: got %b want 10", bus28.err_code); end
        n_checks++; if (bus28.in_ready !== 1'b1) begin n_fail++; $display("FAIL rs_still_second: got %0b want 1", bus28.in_ready); end
        n_checks++; if ({bus28.day1, bus28.mon1} !== {5'd10, 4'd6}) begin n_fail++; $display("FAIL rs_first_kept: got %0d/%0d want 10/6", bus28.day1, bus28.mon1); end
        n_checks++; if (bus28.out_valid !== 1'b0) begin n_fail++; $display("FAIL rs_no_pair: got %0b want 0", bus28.out_valid); end
        tick();
        n_checks++; if (bus28.err !== 1'b0) begin n_fail++; $display("FAIL rs_err_pulse: got %0b want 0", bus28.err); end
        n_checks++; if (bus28.err_code !== 2'b10) begin n_fail++; $display("FAIL rs_code_held: got %b want 10", bus28.err_code); end
        send_date(5'd30, 4'd4);
        n_checks++; if (bus28.out_valid !== 1'b1) begin n_fail++; $display("FAIL rs_pair_valid: got %0b want 1", bus28.out_valid); end
        n_checks++; if ({bus28.day1, bus28.mon1, bus28.day2, bus28.mon2} !== {5'd10, 4'd6, 5'd30, 4'd4}) begin n_fail++; $display("FAIL rs_pair: got %0d/%0d %0d/%0d want 10/6 30/4", bus28.day1, bus28.mon1, bus28.day2, bus28.mon2); end
        bus28.out_ready = 1'b1;
        tick();
        n_checks++; if (bus28.pair_cnt !== 8'(exp_cnt + 1)) begin n_fail++; $display("FAIL rs_cnt: got %0d want %0d", bus28.pair_cnt, exp_cnt + 1); end
        exp_cnt++;
        bus28.out_ready = 1'b0;
    endtask

    task automatic test_reject_vectors;
        logic [4:0] vd[6];
        logic [3:0] vm[6];
        logic [1:0] vc[6];
        vd[0] = 5'd5;  vm[0] = 4'd13; vc[0] = 2'b01;
        vd[1] = 5'd0;  vm[1] = 4'd5;  vc[1] = 2'b10;
        vd[2] = 5'd0;  vm[2] = 4'd0;  vc[2] = 2'b01;
        vd[3] = 5'd29; vm[3] = 4'd2;  vc[3] = 2'b10;
        vd[4] = 5'd31; vm[4] = 4'd11; vc[4] = 2'b10;
        vd[5] = 5'd15; vm[5] = 4'd15; vc[5] = 2'b01;
        for (int i = 0; i < 6; i++) begin
            send_date(vd[i], vm[i]);
            n_checks++; if (bus28.err !== 1'b1) begin n_fail++; $display("FAIL rv_err[%0d/%0d]: got %0b want 1", vd[i], vm[i], bus28.err); end
            n_checks++; if (bus28.err_code !== vc[i]) begin n_fail++; $display("FAIL rv_code[%0d/%0d]: got %b want %b", vd[i], vm[i], bus28.err_code, vc[i]); end
            tick();
            n_checks++; if (bus28.err !== 1'b0) begin n_fail++; $display("FAIL rv_pulse[%0d/%0d]: got %0b want 0", vd[i], vm[i], bus28.err); end
        end
        send_date(5'd31, 4'd12);
        n_checks++; if (bus28.err !== 1'b0) begin n_fail++; $display("FAIL rv_dec31_err: got %0b want 0", bus28.err); end
        send_date(5'd1, 4'd1);
        n_checks++; if (bus28.err !== 1'b0) begin n_fail++; $display("FAIL rv_jan1_err: got %0b want 0", bus28.err); end
        n_checks++; if ({bus28.out_valid, bus28.day1, bus28.mon1, bus28.day2, bus28.mon2} !== {1'b1, 5'd31, 4'd12, 5'd1, 4'd1}) begin n_fail++; $display("FAIL rv_edge_pair: got v=%0b %0d/%0d %0d/%0d want v=1 31/12 1/1", bus28.out_valid, bus28.day1, bus28.mon1, bus28.day2, bus28.mon2); end
        bus28.out_ready = 1'b1;
        tick();
        exp_cnt++;
        bus28.out_ready = 1'b0;
        // Leap-year instance.
        bus29.out_ready = 1'b1;
        send29(5'd29, 4'd2);
        n_checks++; if (bus29.err !== 1'b0) begin n_fail++; $display("FAIL leap_feb29_err: got %0b want 0", bus29.err); end
        send29(5'd30, 4'd2);
        n_checks++; if ({bus29.err, bus29.err_code} !== {1'b1, 2'b10}) begin n_fail++; $display("FAIL leap_feb30: got err=%0b code=%b want err=1 code=10", bus29.err, bus29.err_code); end
        send29(5'd28, 4'd2);
        n_checks++; if ({bus29.out_valid, bus29.day1, bus29.mon1, bus29.day2, bus29.mon2} !== {1'b1, 5'd29, 4'd2, 5'd28, 4'd2}) begin n_fail++; $display("FAIL leap_pair: got v=%0b %0d/%0d %0d/%0d want v=1 29/2 28/2", bus29.out_valid, bus29.day1, bus29.mon1, bus29.day2, bus29.mon2); end
        tick();
        n_checks++; if (bus29.pair_cnt !== 8'd1) begin n_fail++; $display("FAIL leap_cnt: got %0d want 1", bus29.pair_cnt); end
        bus29.out_ready = 1'b0;
    endtask

    task automatic test_clear;
        bus28.out_ready = 1'b0;
        send_date(5'd3, 4'd3);
        bus28.clear    = 1'b1;
        bus28.in_valid = 1'b1;
        bus28.in_day   = 5'd4;
        bus28.in_mon   = 4'd4;
        tick();
        bus28.clear    = 1'b0;
        bus28.in_valid = 1'b0;
        n_checks++; if (bus28.in_ready !== 1'b1) begin n_fail++; $display("FAIL clr2_in_ready: got %0b want 1", bus28.in_ready); end
        n_checks++; if (bus28.out_valid !== 1'b0) begin n_fail++; $display("FAIL clr2_out_valid: got %0b want 0", bus28.out_valid); end
        n_checks++; if ({bus28.day1, bus28.mon1, bus28.day2, bus28.mon2} !== 18'd0) begin n_fail++; $display("FAIL clr2_regs: got %h want 0", {bus28.day1, bus28.mon1, bus28.day2, bus28.mon2}); end
        n_checks++; if (bus28.pair_cnt !== 8'(exp_cnt)) begin n_fail++; $display("FAIL clr2_cnt: got %0d want %0d", bus28.pair_cnt, exp_cnt); end
        send_date(5'd5, 4'd5);
        n_checks++; if ({bus28.in_ready, bus28.out_valid} !== 2'b10) begin n_fail++; $display("FAIL clr_restart_first: got rdy=%0b v=%0b want rdy=1 v=0", bus28.in_ready, bus28.out_valid); end
        send_date(5'd6, 4'd6);
        n_checks++; if ({bus28.out_valid, bus28.day1, bus28.mon1, bus28.day2, bus28.mon2} !== {1'b1, 5'd5, 4'd5, 5'd6, 4'd6}) begin n_fail++; $display("FAIL clr_restart_pair: got v=%0b %0d/%0d %0d/%0d want v=1 5/5 6/6", bus28.out_valid, bus28.day1, bus28.mon1, bus28.day2, bus28.mon2); end
        bus28.clear     = 1'b1;
        bus28.out_ready = 1'b1;
        tick();
        bus28.clear     = 1'b0;
        bus28.out_ready = 1'b0;
        n_checks++; if ({bus28.out_valid, bus28.in_ready} !== 2'b01) begin n_fail++; $display("FAIL clrO_state: got v=%0b rdy=%0b want v=0 rdy=1", bus28.out_valid, bus28.in_ready); end
        n_checks++; if ({bus28.day1, bus28.mon1, bus28.day2, bus28.mon2} !== 18'd0) begin n_fail++; $display("FAIL clrO_regs: got %h want 0", {bus28.day1, bus28.mon1, bus28.day2, bus28.mon2}); end
        n_checks++; if (bus28.pair_cnt !== 8'(exp_cnt)) begin n_fail++; $display("FAIL clrO_cnt_kept: got %0d want %0d", bus28.pair_cnt, exp_cnt); end
        send_date(5'd0, 4'd5);
        bus28.clear = 1'b1;
        tick();
        bus28.clear = 1'b0;
        n_checks++; if ({bus28.err, bus28.err_code} !== 3'b000) begin n_fail++; $display("FAIL clr_err: got err=%0b code=%b want 0 00", bus28.err, bus28.err_code); end
    endtask

    task automatic test_async_reset;
        bus28.out_ready = 1'b0;
        send_date(5'd0, 4'd0);
        send_date(5'd7, 4'd7);
        send_date(5'd8, 4'd8);
        n_checks++; if (bus28.out_valid !== 1'b1) begin n_fail++; $display("FAIL ar_pre_valid: got %0b want 1", bus28.out_valid); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if ({bus28.out_valid, bus28.in_ready} !== 2'b01) begin n_fail++; $display("FAIL ar_state: got v=%0b rdy=%0b want v=0 rdy=1", bus28.out_valid, bus28.in_ready); end
        n_checks++; if ({bus28.day1, bus28.mon1, bus28.day2, bus28.mon2} !== 18'd0) begin n_fail++; $display("FAIL ar_regs: got %h want 0", {bus28.day1, bus28.mon1, bus28.day2, bus28.mon2}); end
        n_checks++; if ({bus28.pair_cnt, bus28.err_code, bus28.err} !== 11'd0) begin n_fail++; $display("FAIL ar_status: got cnt=%0d code=%b err=%0b want 0", bus28.pair_cnt, bus28.err_code, bus28.err); end
        #3 rst_n = 1'b1;
        tick();
        exp_cnt = 0;
    endtask

    task automatic test_back_to_back;
        bus28.out_ready = 1'b1;
        bus28.in_valid  = 1'b1;
        bus28.in_day    = 5'd1;
        bus28.in_mon    = 4'd1;
        for (int k = 1; k <= 256; k++) begin
            tick();
            tick();
            n_checks++; if (bus28.out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %0b want 1", k, bus28.out_valid); end
            tick();
            n_checks++; if (bus28.pair_cnt !== 8'(k % 256)) begin n_fail++; $display("FAIL b2b_cnt[%0d]: got %0d want %0d", k, bus28.pair_cnt, k % 256); end
        end
        bus28.in_valid  = 1'b0;
        bus28.out_ready = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic test_random;
        int held, cnt, d, m, dates, cycles;
        bit iv, orr, acc, bad_m, bad_d, m_err;
        logic [1:0] m_code;
        logic [17:0] m_pair;
        bus28.clear = 1'b1;
        tick();
        bus28.clear = 1'b0;
        held = 0; cnt = exp_cnt; m_code = 2'b00; m_pair = 18'd0; dates = 0; cycles = 0;
        while (dates < 1000 && cycles < 10000) begin
            iv  = ($urandom_range(0, 9) < 7);
            orr = $urandom_range(0, 1) == 1;
            d   = $urandom_range(0, 31);
            m   = $urandom_range(0, 13);
            bus28.in_valid  = iv;
            bus28.in_day    = 5'(d);
            bus28.in_mon    = 4'(m);
            bus28.out_ready = orr;
            if (iv) dates++;
            acc   = iv && (held < 2);
            bad_m = (m == 0) || (m > 12);
            bad_d = (d == 0) || (d > month_len(m, 28));
            m_err = 1'b0;
            if (acc) begin
                if (bad_m || bad_d) begin
                    m_err  = 1'b1;
                    m_code = bad_m ? 2'b01 : 2'b10;
                end else if (held == 0) begin
                    m_pair[17:9] = {5'(d), 4'(m)};
                    held = 1;
                end else begin
                    m_pair[8:0] = {5'(d), 4'(m)};
                    held = 2;
                end
            end else if (held == 2 && orr) begin
                held = 0;
                cnt  = (cnt + 1) % 256;
            end
            tick();
            cycles++;
            n_checks++; if (bus28.in_ready !== (held < 2)) begin n_fail++; $display("FAIL rnd_in_ready@%0d: got %0b want %0b", cycles, bus28.in_ready, held < 2); end
            n_checks++; if (bus28.out_valid !== (held == 2)) begin n_fail++; $display("FAIL rnd_out_valid@%0d: got %0b want %0b", cycles, bus28.out_valid, held == 2); end
            n_checks++; if ({bus28.err, bus28.err_code} !== {m_err, m_code}) begin n_fail++; $display("FAIL rnd_err@%0d: got err=%0b code=%b want err=%0b code=%b", cycles, bus28.err, bus28.err_code, m_err, m_code); end
            n_checks++; if (bus28.pair_cnt !== 8'(cnt)) begin n_fail++; $display("FAIL rnd_cnt@%0d: got %0d want %0d", cycles, bus28.pair_cnt, cnt); end
            if (held == 2) begin
                n_checks++; if ({bus28.day1, bus28.mon1, bus28.day2, bus28.mon2} !== m_pair) begin n_fail++; $display("FAIL rnd_pair@%0d: got %h want %h", cycles, {bus28.day1, bus28.mon1, bus28.day2, bus28.mon2}, m_pair); end
            end
        end
        n_checks++; if (dates < 1000) begin n_fail++; $display("FAIL rnd_budget: got %0d dates want 1000", dates); end
        bus28.in_valid  = 1'b0;
        bus28.out_ready = 1'b0;
    endtask

    initial begin
        bus28.clear = 1'b0; bus28.in_valid = 1'b0; bus28.in_day = 5'd0; bus28.in_mon = 4'd0; bus28.out_ready = 1'b0;
        bus29.clear = 1'b0; bus29.in_valid = 1'b0; bus29.in_day = 5'd0; bus29.in_mon = 4'd0; bus29.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_reject_in_second();
        test_reject_vectors();
        test_clear();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
